// File: rtl/video_timing_pkg.sv
// Default 640x480@60 raster constants, counter width and colour-bar table.
// Shared by the video timing generator, its counter and its output interface.
package video_timing_pkg;

  localparam int VTG_CW = 11;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef logic [VTG_CW-1:0] vtg_cnt_t;

  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle from the timing generator to the renderer/encoders.
// rgb exists only when VTG_PATTERN_EN is defined.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic     hsync;
  logic     vsync;
  logic     de;
  vtg_cnt_t x;
  vtg_cnt_t y;
  logic     sof;
  logic     line_req;
  vtg_cnt_t req_line;
`ifdef VTG_PATTERN_EN
  logic [23:0] rgb;
`endif

  modport master (
    output hsync, vsync, de, x, y,
    output sof, line_req, req_line
`ifdef VTG_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    input hsync, vsync, de, x, y,
    input sof, line_req, req_line
`ifdef VTG_PATTERN_EN
    , input rgb
`endif
  );

endinterface

// File: rtl/vtg_counter.sv
// Wrap-around counter with terminal-count flag; one instance per raster axis.
// clr has priority over inc and returns the counter to the origin.
module vtg_counter #(
  parameter int            CW   = 11,
  parameter logic [CW-1:0] LAST = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock raster timing generator: syncs, de, coords, sof, line fetch.
// Define VTG_PATTERN_EN to add the colour-bar test pattern on rgb.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << VTG_CW) || V_TOTAL > (1 << VTG_CW)) begin : g_bad_cfg
    $error("video_timing_gen: raster too large for counter width");
  end

  localparam vtg_cnt_t H_LAST = VTG_CW'(H_TOTAL - 1);
  localparam vtg_cnt_t V_LAST = VTG_CW'(V_TOTAL - 1);
  localparam vtg_cnt_t HA     = VTG_CW'(H_ACTIVE);
  localparam vtg_cnt_t VA     = VTG_CW'(V_ACTIVE);
  localparam vtg_cnt_t HS_ON  = VTG_CW'(H_ACTIVE + H_FP);
  localparam vtg_cnt_t HS_OFF = VTG_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam vtg_cnt_t VS_ON  = VTG_CW'(V_ACTIVE + V_FP);
  localparam vtg_cnt_t VS_OFF = VTG_CW'(V_ACTIVE + V_FP + V_SYNC);

  vtg_cnt_t h_cnt;
  vtg_cnt_t v_cnt;
  vtg_cnt_t v_next;
  logic     h_tc;
  logic     v_tc;

  vtg_counter #(.CW(VTG_CW), .LAST(H_LAST)) u_h_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (!enable),
    .inc   (enable),
    .cnt   (h_cnt),
    .tc    (h_tc)
  );

  vtg_counter #(.CW(VTG_CW), .LAST(V_LAST)) u_v_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (!enable),
    .inc   (enable & h_tc),
    .cnt   (v_cnt),
    .tc    (v_tc)
  );

  logic     de_c;
  logic     hs_c;
  logic     vs_c;
  logic     sof_c;
  logic     lr_c;
  vtg_cnt_t x_c;
  vtg_cnt_t y_c;
  vtg_cnt_t rl_c;

  // Every term is gated by enable so a disabled cycle registers idle values.
  always_comb begin
    v_next = v_tc ? '0 : v_cnt + 1'b1;
    de_c   = enable && (h_cnt < HA) && (v_cnt < VA);
    hs_c   = enable && (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
    vs_c   = enable && (v_cnt >= VS_ON) && (v_cnt < VS_OFF);
    sof_c  = enable && (h_cnt == '0) && (v_cnt == '0);
    lr_c   = enable && (h_cnt == HA) && (v_next < VA);
    x_c    = de_c ? h_cnt : '0;
    y_c    = de_c ? v_cnt : '0;
    rl_c   = lr_c ? v_next : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vid.hsync    <= !HS_POL;
      vid.vsync    <= !VS_POL;
      vid.de       <= 1'b0;
      vid.x        <= '0;
      vid.y        <= '0;
      vid.sof      <= 1'b0;
      vid.line_req <= 1'b0;
      vid.req_line <= '0;
    end else begin
      vid.hsync    <= hs_c ? HS_POL : !HS_POL;
      vid.vsync    <= vs_c ? VS_POL : !VS_POL;
      vid.de       <= de_c;
      vid.x        <= x_c;
      vid.y        <= y_c;
      vid.sof      <= sof_c;
      vid.line_req <= lr_c;
      vid.req_line <= rl_c;
    end
  end

`ifdef VTG_PATTERN_EN
  localparam vtg_cnt_t BAR_W = VTG_CW'(H_ACTIVE / 8);

  logic [2:0] bar_idx;

  assign bar_idx = 3'(h_cnt / BAR_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vid.rgb <= '0;
    else         vid.rgb <= de_c ? BAR_RGB[bar_idx] : '0;
  end
`endif

endmodule
